// File: rtl/mrd_multi_chan_requestor.sv
// mrd_multi_chan_requestor
//   Shared host-to-card memory-read request engine. Accepts whole read bursts
//   from NUM_CHANS scatter-gather channels, splits each burst into chunks no
//   larger than the max read request size, allocates a tag per chunk and
//   presents the chunks to the MRd arbiter round-robin across channels.
//   Outstanding chunks are capped per channel (MAX_PENDING) and released by
//   completion feedback.
//
//   Optional build macro: MRD_4K_BOUNDARY_SPLIT_EN
//     defined   - chunks are additionally cut so they never cross a 4 KB boundary
//     undefined - chunks are limited by remaining length and MRRS only
//
// Ports
//   s_axi_clk, s_axi_rstn        clock, asynchronous active-low reset
//   max_read_request_size        MRRS in bytes (128..4096, power of two)
//   chan_req/chan_rdy            per-channel burst handshake
//   chan_len, chan_addr          per-channel burst length (bytes) and start address
//   chan_done                    1-cycle pulse after the last chunk of a burst is granted
//   alloc_tag_req                1-cycle tag request pulse
//   allocated_tag_rdy/_tag       tag returned by the allocator
//   mrd_req_arbit_req/_grnt      request/grant towards the MRd arbiter
//   mrd_req_burst_len_out        chunk length in bytes
//   mrd_req_burst_sys_addr_out   chunk address (zero-extended to 64 bits)
//   mrd_req_burst_tag            chunk tag
//   mrd_req_context              {channel[7:0], tag[7:0], sequence[15:0]}
//   cpl_done_valid/_chan         one chunk of the given channel fully completed

module mrd_multi_chan_requestor #(
  parameter int unsigned NUM_CHANS   = 4,
  parameter int unsigned MAX_PENDING = 2,
  parameter int unsigned ADDR_WIDTH  = 64
) (
  input  logic                             s_axi_clk,
  input  logic                             s_axi_rstn,
  input  logic [12:0]                      max_read_request_size,
  input  logic [NUM_CHANS-1:0]             chan_req,
  output logic [NUM_CHANS-1:0]             chan_rdy,
  input  logic [13*NUM_CHANS-1:0]          chan_len,
  input  logic [ADDR_WIDTH*NUM_CHANS-1:0]  chan_addr,
  output logic [NUM_CHANS-1:0]             chan_done,
  output logic                             alloc_tag_req,
  input  logic                             allocated_tag_rdy,
  input  logic [7:0]                       allocated_tag,
  output logic                             mrd_req_arbit_req,
  input  logic                             mrd_req_arbit_grnt,
  output logic [12:0]                      mrd_req_burst_len_out,
  output logic [63:0]                      mrd_req_burst_sys_addr_out,
  output logic [7:0]                       mrd_req_burst_tag,
  output logic [31:0]                      mrd_req_context,
  input  logic                             cpl_done_valid,
  input  logic [3:0]                       cpl_done_chan
);

  localparam int unsigned CW   = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;
  localparam logic [3:0]  MAXP = 4'(MAX_PENDING);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_TAG, S_REQ, S_UPD} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q [NUM_CHANS];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_CHANS];
  logic [12:0]           rem_q  [NUM_CHANS];
  logic [12:0]           rem_d  [NUM_CHANS];
  logic [3:0]            pend_q [NUM_CHANS];
  logic [3:0]            pend_d [NUM_CHANS];
  logic [15:0]           seq_q  [NUM_CHANS];
  logic [15:0]           seq_d  [NUM_CHANS];

  logic [NUM_CHANS-1:0]  accept, inc, dec, done_d;
  logic [NUM_CHANS-1:0]  elig;     // eligibility from current state
  logic [NUM_CHANS-1:0]  elig_nx;  // eligibility after this cycle's updates

  logic [CW-1:0]         last_q, sel_q, pick;
  logic                  pick_vld;
  int unsigned           idx;
  logic [12:0]           clen, clen_q;

  // Per-channel next state: burst load, chunk retire, pending bookkeeping.
  always_comb begin
    accept  = '0;
    inc     = '0;
    dec     = '0;
    done_d  = '0;
    elig    = '0;
    elig_nx = '0;
    chan_rdy = '0;
    for (int unsigned i = 0; i < NUM_CHANS; i++) begin
      addr_d[i] = addr_q[i];
      rem_d[i]  = rem_q[i];
      pend_d[i] = pend_q[i];
      seq_d[i]  = seq_q[i];

      chan_rdy[i] = (rem_q[i] == 13'd0);
      accept[i]   = chan_req[i] & chan_rdy[i];
      inc[i]      = (state_q == S_UPD) && (sel_q == CW'(i));
      // channel numbers outside 0..NUM_CHANS-1 never match any i
      dec[i]      = cpl_done_valid && (cpl_done_chan == 4'(i));

      if (accept[i]) begin
        addr_d[i] = chan_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        rem_d[i]  = chan_len[13*i +: 13];
      end else if (inc[i]) begin
        addr_d[i] = addr_q[i] + ADDR_WIDTH'(clen_q);
        rem_d[i]  = rem_q[i] - clen_q;
        seq_d[i]  = seq_q[i] + 16'd1;
      end

      // simultaneous increment and decrement cancel; decrement at zero is dropped
      if (inc[i] && !dec[i])
        pend_d[i] = pend_q[i] + 4'd1;
      else if (!inc[i] && dec[i] && (pend_q[i] != 4'd0))
        pend_d[i] = pend_q[i] - 4'd1;

      elig[i]    = (rem_q[i] != 13'd0) && (pend_q[i] < MAXP);
      elig_nx[i] = (rem_d[i] != 13'd0) && (pend_d[i] < MAXP);

      done_d[i] = (accept[i] && (chan_len[13*i +: 13] == 13'd0)) ||
                  ((state_q == S_REQ) && mrd_req_arbit_grnt &&
                   (sel_q == CW'(i)) && (clen_q == rem_q[i]));
    end
  end

  // Round-robin pick, starting at the channel after the last one served.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_CHANS; k++) begin
      idx = (32'(last_q) + k) % NUM_CHANS;
      if (!pick_vld && elig[idx]) begin
        pick     = CW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Chunk length for the picked channel.
`ifdef MRD_4K_BOUNDARY_SPLIT_EN
  logic [12:0] to_4k;
  always_comb begin
    to_4k = 13'd4096 - {1'b0, addr_q[pick][11:0]};
    clen  = rem_q[pick];
    if (max_read_request_size < clen) clen = max_read_request_size;
    if (to_4k < clen) clen = to_4k;
  end
`else
  always_comb begin
    clen = rem_q[pick];
    if (max_read_request_size < clen) clen = max_read_request_size;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|elig) state_d = S_ARB;
      S_ARB:   state_d = pick_vld ? S_TAG : S_IDLE;
      S_TAG:   if (allocated_tag_rdy) state_d = S_REQ;
      S_REQ:   if (mrd_req_arbit_grnt) state_d = S_UPD;
      S_UPD:   state_d = (|elig_nx) ? S_ARB : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      for (int unsigned i = 0; i < NUM_CHANS; i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
        pend_q[i] <= '0;
        seq_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CHANS; i++) begin
        addr_q[i] <= addr_d[i];
        rem_q[i]  <= rem_d[i];
        pend_q[i] <= pend_d[i];
        seq_q[i]  <= seq_d[i];
      end
    end
  end

  // Chunk selection and registered outputs; the request bundle is loaded
  // only on entry to REQ and held until the grant.
  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      last_q                     <= CW'(NUM_CHANS - 1);
      sel_q                      <= '0;
      clen_q                     <= '0;
      chan_done                  <= '0;
      alloc_tag_req              <= 1'b0;
      mrd_req_arbit_req          <= 1'b0;
      mrd_req_burst_len_out      <= '0;
      mrd_req_burst_sys_addr_out <= '0;
      mrd_req_burst_tag          <= '0;
      mrd_req_context            <= '0;
    end else begin
      chan_done     <= done_d;
      alloc_tag_req <= (state_q == S_ARB) && pick_vld;
      if ((state_q == S_ARB) && pick_vld) begin
        sel_q  <= pick;
        last_q <= pick;
        clen_q <= clen;
      end
      if ((state_q == S_TAG) && allocated_tag_rdy) begin
        mrd_req_arbit_req          <= 1'b1;
        mrd_req_burst_len_out      <= clen_q;
        mrd_req_burst_sys_addr_out <= 64'(addr_q[sel_q]);
        mrd_req_burst_tag          <= allocated_tag;
        mrd_req_context            <= {8'(sel_q), allocated_tag, seq_q[sel_q]};
      end
      if ((state_q == S_REQ) && mrd_req_arbit_grnt)
        mrd_req_arbit_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mrd_multi_chan_requestor.sv
module tb_mrd_multi_chan_requestor;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [12:0]      mrrs = 13'd256;
  logic [NC-1:0]    chan_req = '0;
  logic [NC-1:0]    chan_rdy, chan_done;
  logic [13*NC-1:0] chan_len = '0;
  logic [64*NC-1:0] chan_addr = '0;
  logic             alloc_tag_req, tag_rdy;
  logic [7:0]       tag_val, tag_ctr;
  logic             arb, gnt;
  logic             gnt_en = 1'b1;
  logic [12:0]      blen;
  logic [63:0]      baddr;
  logic [7:0]       btag;
  logic [31:0]      ctx;
  logic             cpl_valid = 1'b0;
  logic [3:0]       cpl_chan = '0;

  mrd_multi_chan_requestor #(.NUM_CHANS(NC), .MAX_PENDING(2), .ADDR_WIDTH(64)) dut (
    .s_axi_clk                  (clk),
    .s_axi_rstn                 (rst_n),
    .max_read_request_size      (mrrs),
    .chan_req                   (chan_req),
    .chan_rdy                   (chan_rdy),
    .chan_len                   (chan_len),
    .chan_addr                  (chan_addr),
    .chan_done                  (chan_done),
    .alloc_tag_req              (alloc_tag_req),
    .allocated_tag_rdy          (tag_rdy),
    .allocated_tag              (tag_val),
    .mrd_req_arbit_req          (arb),
    .mrd_req_arbit_grnt         (gnt),
    .mrd_req_burst_len_out      (blen),
    .mrd_req_burst_sys_addr_out (baddr),
    .mrd_req_burst_tag          (btag),
    .mrd_req_context            (ctx),
    .cpl_done_valid             (cpl_valid),
    .cpl_done_chan              (cpl_chan)
  );

  // zero-wait tag allocator handing out 0,1,2,... after reset
  assign tag_rdy = alloc_tag_req;
  assign tag_val = tag_ctr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tag_ctr <= 8'd0;
    else if (alloc_tag_req) tag_ctr <= tag_ctr + 8'd1;

  assign gnt = arb & gnt_en;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_alloc = 0;
  int n_arb = 0;
  int done_cnt [NC];
  bit auto_cpl = 1'b0;
  logic [12:0] g_len [$];
  logic [63:0] g_addr [$];
  logic [7:0]  g_tag [$];
  logic [31:0] g_ctx [$];
  int          g_cyc [$];
  int          cplq [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (arb && gnt) begin
        g_len.push_back(blen);
        g_addr.push_back(baddr);
        g_tag.push_back(btag);
        g_ctx.push_back(ctx);
        g_cyc.push_back(cyc);
        if (auto_cpl) cplq.push_back(int'(ctx[31:24]));
      end
      if (alloc_tag_req) n_alloc++;
      if (arb) n_arb++;
      for (int i = 0; i < NC; i++) if (chan_done[i]) done_cnt[i]++;
    end
  end

  // completion feedback, one per cycle from the queue
  always @(posedge clk) begin
    #1;
    cpl_valid = 1'b0;
    cpl_chan  = 4'd0;
    if (cplq.size() > 0) begin
      cpl_chan  = 4'(cplq.pop_front());
      cpl_valid = 1'b1;
    end
  end

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chan_req = '0;
    run(2);
    g_len.delete(); g_addr.delete(); g_tag.delete(); g_ctx.delete(); g_cyc.delete();
    cplq.delete();
    n_alloc = 0; n_arb = 0;
    for (int i = 0; i < NC; i++) done_cnt[i] = 0;
    rst_n = 1'b1;
    run(1);
  endtask

  task automatic send(input int ch, input logic [63:0] a, input logic [12:0] l);
    int n = 0;
    while (!chan_rdy[ch] && n < 200) begin run(1); n++; end
    check("send_rdy", 64'(chan_rdy[ch]), 64'd1);
    chan_req[ch] = 1'b1;
    chan_len[ch*13 +: 13] = l;
    chan_addr[ch*64 +: 64] = a;
    run(1);
    chan_req[ch] = 1'b0;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    run(2);
    // reset state
    check("rst_rdy", 64'(chan_rdy), 64'hF);
    check("rst_arb", 64'(arb), 64'd0);
    check("rst_alloc", 64'(alloc_tag_req), 64'd0);
    check("rst_done", 64'(chan_done), 64'd0);
    check("rst_len", 64'(blen), 64'd0);
    check("rst_addr", baddr, 64'd0);
    check("rst_ctx", 64'(ctx), 64'd0);
    check("rst_tag", 64'(btag), 64'd0);

    // 1: ch0 1024 bytes at 0x1000, MRRS 256 -> 4 chunks
    do_reset();
    mrrs = 13'd256; auto_cpl = 1'b1;
    send(0, 64'h1000, 13'd1024);
    run(2);
    check("t1_alloc", 64'(alloc_tag_req), 64'd1);
    check("t1_lat_lo", 64'(arb), 64'd0);
    run(1);
    check("t1_lat_hi", 64'(arb), 64'd1);
    run(40);
    check("t1_n", 64'(g_len.size()), 64'd4);
    for (int k = 0; k < 4; k++) if (k < g_len.size()) begin
      check("t1_addr", g_addr[k], 64'h1000 + 64'(256 * k));
      check("t1_len", 64'(g_len[k]), 64'd256);
      check("t1_ctx", 64'(g_ctx[k]), 64'({8'd0, 8'(k), 16'(k)}));
      check("t1_tag", 64'(g_tag[k]), 64'(k));
    end
    if (g_cyc.size() >= 2) check("t1_gap", 64'(g_cyc[1] - g_cyc[0]), 64'd4);
    check("t1_done", 64'(done_cnt[0]), 64'd1);

    // 2: ch1 512 bytes at 0x0F80, MRRS 512
    do_reset();
    mrrs = 13'd512; auto_cpl = 1'b1;
    send(1, 64'h0F80, 13'd512);
    run(30);
`ifdef MRD_4K_BOUNDARY_SPLIT_EN
    check("t2_n", 64'(g_len.size()), 64'd2);
    if (g_len.size() >= 2) begin
      check("t2_len0", 64'(g_len[0]), 64'd128);
      check("t2_addr0", g_addr[0], 64'h0F80);
      check("t2_len1", 64'(g_len[1]), 64'd384);
      check("t2_addr1", g_addr[1], 64'h1000);
      check("t2_ctx1", 64'(g_ctx[1]), 64'h0101_0001);
    end
`else
    check("t2_n", 64'(g_len.size()), 64'd1);
    if (g_len.size() >= 1) begin
      check("t2_len0", 64'(g_len[0]), 64'd512);
      check("t2_addr0", g_addr[0], 64'h0F80);
      check("t2_ctx0", 64'(g_ctx[0]), 64'h0100_0000);
    end
`endif
    check("t2_done", 64'(done_cnt[1]), 64'd1);

    // 3: pending cap, out-of-range completion ignored, release by completion
    do_reset();
    mrrs = 13'd256; auto_cpl = 1'b0;
    send(0, 64'h2000, 13'd1024);
    run(40);
    check("t3_cap", 64'(g_len.size()), 64'd2);
    check("t3_arb_lo", 64'(arb), 64'd0);
    cplq.push_back(5);
    run(15);
    check("t3_badchan", 64'(g_len.size()), 64'd2);
    cplq.push_back(0);
    run(20);
    check("t3_rel", 64'(g_len.size()), 64'd3);
    if (g_len.size() >= 3) begin
      check("t3_addr", g_addr[2], 64'h2200);
      check("t3_ctx", 64'(g_ctx[2]), 64'h0002_0002);
    end
    check("t3_nodone", 64'(done_cnt[0]), 64'd0);

    // 4: all channels, 2 chunks each -> round-robin order
    do_reset();
    mrrs = 13'd256; auto_cpl = 1'b1;
    for (int c = 0; c < NC; c++) begin
      chan_len[c*13 +: 13]  = 13'd512;
      chan_addr[c*64 +: 64] = 64'h10000 * 64'(c + 1);
    end
    chan_req = '1;
    run(1);
    chan_req = '0;
    run(80);
    check("t4_n", 64'(g_ctx.size()), 64'd8);
    for (int k = 0; k < 8; k++) if (k < g_ctx.size()) begin
      check("t4_ctx", 64'(g_ctx[k]), 64'({8'(k % 4), 8'(k), 16'(k / 4)}));
      check("t4_addr", g_addr[k], 64'h10000 * 64'(k % 4 + 1) + 64'(256 * (k / 4)));
    end
    for (int c = 0; c < NC; c++) check("t4_done", 64'(done_cnt[c]), 64'd1);

    // 5: zero-length burst on ch2
    do_reset();
    send(2, 64'h3000, 13'd0);
    check("t5_pulse", 64'(chan_done), 64'b0100);
    run(1);
    check("t5_pulse_end", 64'(chan_done), 64'd0);
    run(20);
    check("t5_alloc", 64'(n_alloc), 64'd0);
    check("t5_arb", 64'(n_arb), 64'd0);
    check("t5_done", 64'(done_cnt[2]), 64'd1);

    // 6: reset while in REQ
    do_reset();
    mrrs = 13'd256; gnt_en = 1'b0;
    send(3, 64'h4000, 13'd512);
    n = 0;
    while (!arb && n < 50) begin run(1); n++; end
    check("t6_inreq", 64'(arb), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_arb_drop", 64'(arb), 64'd0);
    check("t6_rdy", 64'(chan_rdy), 64'hF);
    gnt_en = 1'b1;
    do_reset();
    send(3, 64'h5000, 13'd256);
    run(20);
    check("t6_n", 64'(g_ctx.size()), 64'd1);
    if (g_ctx.size() >= 1) begin
      check("t6_ctx", 64'(g_ctx[0]), 64'h0300_0000);
      check("t6_addr", g_addr[0], 64'h5000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mrd_multi_chan_requestor.md
# mrd_multi_chan_requestor

Parametrised multi-channel memory-read (MRd) request engine for the host-to-card (S2C) path. It accepts whole read bursts from up to NUM_CHANS scatter-gather channels and splits each burst into PCIe-legal chunks. It allocates a tag per chunk and issues the chunks to the MRd arbiter, round-robin across channels. Outstanding chunks are capped per channel and released by completion feedback. It replaces one single-channel requestor per channel with one shared engine.

## Interface
- NUM_CHANS, 4, number of channels (1..16)
- MAX_PENDING, 2, max outstanding chunks per channel (1..15)
- ADDR_WIDTH, 64, system address width
- s_axi_clk  in  1  sole clock
- s_axi_rstn  in  1  reset; one clock, asynchronous assert, active-low
- max_read_request_size  in  13  MRRS in bytes, power of two 128..4096, static while any burst is active
- chan_req  in  NUM_CHANS  burst request per channel
- chan_rdy  out  NUM_CHANS  channel may accept a burst; a burst is accepted on chan_req & chan_rdy
- chan_len  in  13*NUM_CHANS  burst length in bytes, 1..4096; 0 means empty burst
- chan_addr  in  ADDR_WIDTH*NUM_CHANS  burst start address
- chan_done  out  NUM_CHANS  1-cycle pulse when the last chunk of a burst is granted
- alloc_tag_req  out  1  1-cycle tag request pulse
- allocated_tag_rdy  in  1  tag valid
- allocated_tag  in  8  allocated tag
- mrd_req_arbit_req  out  1  request to the MRd arbiter
- mrd_req_arbit_grnt  in  1  arbiter grant; consumes the chunk
- mrd_req_burst_len_out  out  13  chunk length in bytes
- mrd_req_burst_sys_addr_out  out  64  chunk address, zero-extended
- mrd_req_burst_tag  out  8  chunk tag
- mrd_req_context  out  32  [31:24] channel, [23:16] tag, [15:0] per-channel chunk sequence number
- cpl_done_valid  in  1  a chunk has fully completed
- cpl_done_chan  in  4  channel of the completed chunk

## Operation
- Per-channel state: address, remaining byte count, pending count, and a 16-bit sequence counter that wraps and clears on reset.
- chan_rdy[i] = (remaining[i] == 0).
- Burst accepted with length 0: no MRd is issued; chan_done[i] pulses on the next cycle.
- A channel is eligible when remaining != 0 and pending < MAX_PENDING.
- FSM states:
  - IDLE → ARB when any channel is eligible.
  - ARB: round-robin pick, starting after the last served channel; computes the chunk; → TAG.
  - TAG: pulse alloc_tag_req, wait for allocated_tag_rdy, latch the tag; → REQ.
  - REQ: hold arbit_req and all outputs stable until grant; on grant → UPD.
  - UPD: address += chunk, remaining -= chunk, pending++, seq++; chan_done if remaining becomes 0; → ARB if any channel is eligible, else IDLE.
- Chunk length = min(remaining, MRRS, 4096 − addr[11:0]). The 4096 − addr[11:0] term applies only with the 4K-split macro defined.
- Pending count: cpl_done_valid decrements pending[cpl_done_chan]. A decrement and a UPD increment on the same channel in the same cycle leave the count unchanged. A decrement at count 0 is ignored. A cpl_done_chan value ≥ NUM_CHANS is ignored.

## Timing
- Reset values: all outputs 0, chan_rdy all 1, FSM in IDLE, round-robin pointer at channel NUM_CHANS−1 (so channel 0 is served first).
- Latency from burst acceptance to arbit_req: 3 cycles plus tag wait (ARB, TAG, REQ entry).
- arbit_req deasserts in the cycle after the grant.
- mrd_req_burst_* outputs and mrd_req_context change only on entry to REQ.
- Back-to-back chunks: minimum 4 cycles per chunk with a zero-wait tag and grant.
- Reset asserted mid-operation: all state clears immediately. The tag in flight is dropped; the tag allocator is reset by the same reset.

## Configuration
- MRD_4K_BOUNDARY_SPLIT_EN defined: chunks never cross a 4 KB address boundary.
- Not defined: chunks are limited by MRRS and remaining only. The caller must supply bursts that do not cross a 4 KB boundary at an MRRS-aligned offset.

## Test plan
- Ch0, addr 0x1000, len 1024, MRRS 256 → 4 chunks at 0x1000/0x1100/0x1200/0x1300, len 256 each, seq 0..3; chan_done[0] pulses once, after the 4th grant.
- Macro defined, ch1, addr 0x0F80, len 512, MRRS 512 → chunks of 128 at 0x0F80 and 384 at 0x1000. Macro undefined → a single chunk of 512 at 0x0F80.
- MAX_PENDING 2, no completions, ch0 burst of 4 chunks → exactly 2 grants, then arbit_req stays low. One cpl_done_valid for ch0 → 3rd chunk issued.
- All 4 channels request 2 chunks each → grant order ch0, ch1, ch2, ch3, ch0, ch1, ch2, ch3.
- Len 0 on ch2 → chan_done[2] pulses the next cycle; no alloc_tag_req and no arbit_req occur.
- Reset asserted while in REQ → arbit_req drops to 0 at once; chan_rdy returns to all 1; the first request after reset carries seq 0.
